// File: rtl/stack_pkg.sv
// Shared state encoding and default geometry for the stacking game controller.
package stack_pkg;
   // FSM state encoding, also driven out on the state port
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MOVE = 3'd1;
   localparam logic [2:0] S_TRIM = 3'd2;
   localparam logic [2:0] S_OVER = 3'd3;

   // Horizontal direction of the moving block
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Default playfield geometry
   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_START_X  = 270;
   localparam int DEF_START_W  = 100;
   localparam int DEF_BASE_Y   = 360;
   localparam int DEF_BLOCK_H  = 20;
   localparam int DEF_SPEED    = 2;
   localparam int DEF_MAX_LVL  = 15;
endpackage

// File: rtl/stack_overlap.sv
// Overlap of the dropped span against the top stacked span.
// 11-bit sums so x+w never wraps; a touching edge (R==L) is a miss.
module stack_overlap
   import stack_pkg::*;
(
   input  logic [9:0] a_x,
   input  logic [9:0] a_w,
   input  logic [9:0] b_x,
   input  logic [9:0] b_w,
   output logic [9:0] l,
   output logic [9:0] span,
   output logic       miss
);
   logic [10:0] a_r, b_r, lo, hi, diff;

   // Left edge is the larger start, right edge the smaller end
   always_comb begin
      a_r  = {1'b0, a_x} + {1'b0, a_w};
      b_r  = {1'b0, b_x} + {1'b0, b_w};
      lo   = (a_x > b_x) ? {1'b0, a_x} : {1'b0, b_x};
      hi   = (a_r < b_r) ? a_r : b_r;
      miss = (hi <= lo);
      diff = hi - lo;
      l    = lo[9:0];
      span = miss ? 10'd0 : diff[9:0];
   end
endmodule

// File: rtl/stack_ctrl.sv
// Stacking game controller: moves a block back and forth, trims it against
// the stack on drop, and tracks height, loss and win.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int START_X   = DEF_START_X,
   parameter int START_W   = DEF_START_W,
   parameter int BASE_Y    = DEF_BASE_Y,
   parameter int BLOCK_H   = DEF_BLOCK_H,
   parameter int SPEED     = DEF_SPEED,
   parameter int MAX_LEVEL = DEF_MAX_LVL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       drop,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [9:0] width,
   output logic [9:0] base_x,
   output logic [9:0] base_w,
   output logic [9:0] height,
   output logic       game_over,
   output logic       win,
   output logic [2:0] state
);
   logic        dir;
   logic [9:0]  ov_l, ov_w;
   logic        ov_miss;
   logic [10:0] right_lim;
   logic [9:0]  next_h;

   stack_overlap u_overlap (
      .a_x  (pos_x),
      .a_w  (width),
      .b_x  (base_x),
      .b_w  (base_w),
      .l    (ov_l),
      .span (ov_w),
      .miss (ov_miss)
   );

   // Rightmost legal x for the current width, and height after a hit
   always_comb begin
      right_lim = 11'(SCREEN_W) - {1'b0, width};
      next_h    = height + 10'd1;
   end

   // Game FSM; a start in OVER returns to the reset values, like rst
   always_ff @(posedge clk) begin
      if (rst || (state == S_OVER && start)) begin
         state     <= S_IDLE;
         pos_x     <= 10'(START_X);
         pos_y     <= 10'(BASE_Y);
         width     <= 10'(START_W);
         base_x    <= 10'(START_X);
         base_w    <= 10'(START_W);
         height    <= 10'd1;
         dir       <= DIR_RIGHT;
         game_over <= 1'b0;
         win       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_MOVE;
                  pos_x <= 10'd0;
                  dir   <= DIR_RIGHT;
                  pos_y <= 10'(BASE_Y - int'(height) * BLOCK_H);
               end
            end
            S_MOVE: begin
               // drop freezes the block even if a tick arrives with it
               if (drop) begin
                  state <= S_TRIM;
               end else if (tick) begin
                  if (dir == DIR_RIGHT) begin
                     if ({1'b0, pos_x} + 11'(SPEED) >= right_lim) begin
                        pos_x <= right_lim[9:0];
                        dir   <= DIR_LEFT;
                     end else begin
                        pos_x <= pos_x + 10'(SPEED);
                     end
                  end else begin
                     if (pos_x <= 10'(SPEED)) begin
                        pos_x <= 10'd0;
                        dir   <= DIR_RIGHT;
                     end else begin
                        pos_x <= pos_x - 10'(SPEED);
                     end
                  end
               end
            end
            S_TRIM: begin
               if (ov_miss) begin
                  state     <= S_OVER;
                  game_over <= 1'b1;
               end else begin
                  base_x <= ov_l;
                  base_w <= ov_w;
                  width  <= ov_w;
                  height <= next_h;
                  if (next_h == 10'(MAX_LEVEL)) begin
                     state     <= S_OVER;
                     win       <= 1'b1;
                     game_over <= 1'b1;
                  end else begin
                     state <= S_MOVE;
                     pos_x <= 10'd0;
                     dir   <= DIR_RIGHT;
                     pos_y <= pos_y - 10'(BLOCK_H);
                  end
               end
            end
            default: ;  // OVER holds everything until start
         endcase
      end
   end
endmodule
